// File: rtl/rsa_skew_feeder.sv
// Input stage of the systolic array: accepts unskewed K-slices over valid/ready
// and emits diagonally skewed A/B lanes with per-column cal_en/cal_done markers.
module rsa_skew_feeder #(
    parameter int X      = 4,
    parameter int Y      = 4,
    parameter int L      = 4,
    parameter int RSA_DW = 32
) (
    input  logic                clk,
    input  logic                sys_rst,
    input  logic                start,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [X*RSA_DW-1:0] A_in,
    input  logic [Y*RSA_DW-1:0] B_in,
    output logic [X*RSA_DW-1:0] A_data,
    output logic [Y*RSA_DW-1:0] B_data,
    output logic [Y-1:0]        new_cal_en,
    output logic [Y-1:0]        new_cal_done,
    output logic                busy,
    output logic                done
);

    localparam int MAXXY = (X > Y) ? X : Y;
    localparam int D     = MAXXY - 1;
    localparam int DLAST = (D > 0) ? D - 1 : 0;
    localparam int KW    = $clog2(L + 1);
    localparam int DCW   = $clog2(MAXXY + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FEED  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [KW-1:0]  r_k;
    logic [KW-1:0]  w_k_next;
    logic [DCW-1:0] r_dcnt;
    logic [DCW-1:0] w_dcnt_next;
    logic           r_in_ready;
    logic           r_busy;
    logic           r_done;
    logic           w_accept;
    logic           w_last;

    assign w_accept = in_valid && (r_state == S_FEED);
    assign w_last   = w_accept && (r_k == KW'(L - 1));

    always_comb begin
        w_state_next = r_state;
        w_k_next     = r_k;
        w_dcnt_next  = r_dcnt;
        case (r_state)
            S_IDLE: begin
                w_k_next = '0;
                if (start) begin
                    w_state_next = S_FEED;
                end
            end
            S_FEED: begin
                if (w_accept) begin
                    if (w_last) begin
                        w_k_next     = '0;
                        w_dcnt_next  = '0;
                        w_state_next = (D == 0) ? S_DONE : S_DRAIN;
                    end else begin
                        w_k_next = r_k + KW'(1);
                    end
                end
            end
            S_DRAIN: begin
                // Shift zeros until the last beat reaches the deepest lane.
                if (r_dcnt == DCW'(DLAST)) begin
                    w_dcnt_next  = '0;
                    w_state_next = S_DONE;
                end else begin
                    w_dcnt_next = r_dcnt + DCW'(1);
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_state    <= S_IDLE;
            r_k        <= '0;
            r_dcnt     <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_k        <= w_k_next;
            r_dcnt     <= w_dcnt_next;
            // Status outputs are registered from the next state so they track r_state.
            r_in_ready <= (w_state_next == S_FEED);
            r_busy     <= (w_state_next != S_IDLE);
            r_done     <= (w_state_next == S_DONE);
        end
    end

    assign in_ready = r_in_ready;
    assign busy     = r_busy;
    assign done     = r_done;

    genvar gi;

    // Lane gi of A carries gi extra stages behind the common stage 0.
    generate
        for (gi = 0; gi < X; gi++) begin : g_a_lane
            logic [RSA_DW-1:0] r_a_sr [0:gi];

            always_ff @(posedge clk or negedge sys_rst) begin
                if (!sys_rst) begin
                    for (int s = 0; s <= gi; s++) begin
                        r_a_sr[s] <= '0;
                    end
                end else begin
                    r_a_sr[0] <= w_accept ? A_in[gi*RSA_DW +: RSA_DW] : '0;
                    for (int s = 1; s <= gi; s++) begin
                        r_a_sr[s] <= r_a_sr[s-1];
                    end
                end
            end

            assign A_data[gi*RSA_DW +: RSA_DW] = r_a_sr[gi];
        end
    endgenerate

    // B lanes carry their cal_en/cal_done markers through identical depth.
    generate
        for (gi = 0; gi < Y; gi++) begin : g_b_lane
            logic [RSA_DW-1:0] r_b_sr  [0:gi];
            logic              r_en_sr [0:gi];
            logic              r_dn_sr [0:gi];

            always_ff @(posedge clk or negedge sys_rst) begin
                if (!sys_rst) begin
                    for (int s = 0; s <= gi; s++) begin
                        r_b_sr[s]  <= '0;
                        r_en_sr[s] <= 1'b0;
                        r_dn_sr[s] <= 1'b0;
                    end
                end else begin
                    r_b_sr[0]  <= w_accept ? B_in[gi*RSA_DW +: RSA_DW] : '0;
                    r_en_sr[0] <= w_accept;
                    r_dn_sr[0] <= w_last;
                    for (int s = 1; s <= gi; s++) begin
                        r_b_sr[s]  <= r_b_sr[s-1];
                        r_en_sr[s] <= r_en_sr[s-1];
                        r_dn_sr[s] <= r_dn_sr[s-1];
                    end
                end
            end

            assign B_data[gi*RSA_DW +: RSA_DW] = r_b_sr[gi];
            assign new_cal_en[gi]              = r_en_sr[gi];
            assign new_cal_done[gi]            = r_dn_sr[gi];
        end
    endgenerate

endmodule
